// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state enum, default width, counter width and sentinel.
package seq_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } div_state_e;

  localparam int DIV_N = 8;

  localparam int DIV_CNT_W = $clog2(DIV_N + 1);

  localparam logic [DIV_N-1:0] DIV_SENTINEL = '1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational W-bit subtract a - b with borrow-out.
// Ports: a_i, b_i operands; diff_o result; borrow_o set when a_i < b_i.
module div_sub_stage #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  // a + ~b + 1 through a ripple of full-adder cells.
  logic [W:0]   c;
  logic [W-1:0] nb;

  assign c[0] = 1'b1;
  assign nb   = ~b_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic p;
    assign p         = a_i[i] ^ nb[i];
    assign diff_o[i] = p ^ c[i];
    assign c[i+1]    = (a_i[i] & nb[i]) | (p & c[i]);
  end

  // No carry-out of the inverted-add means the subtraction borrowed.
  assign borrow_o = ~c[W];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor.
// Ports: clk, rst, start, A, B in; busy, done, q, r, dz, ovf out.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           dz,
  output logic           ovf
);

  localparam int CW = cnt_width(N);

  div_state_e   state_q, state_d;
  logic [N:0]   part_q, part_d;
  logic [N-1:0] sh_q, sh_d;
  logic [N-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] r_q, r_d;
  logic         dz_q, dz_d;
  logic         ovf_q, ovf_d;

  logic [N:0]   trial;
  logic [N:0]   diff;
  logic         borrow;
  logic [N:0]   part_nx;
  logic [N-1:0] quo_nx;
  logic         part_msb_unused;

  // The partial remainder stays below B, so its top bit is always 0.
  assign part_msb_unused = part_q[N];

  // sh_q shifts dividend bits out of the MSB and quotient bits in at the LSB.
  assign trial = {part_q[N-1:0], sh_q[N-1]};

  div_sub_stage #(
    .W(N + 1)
  ) u_sub (
    .a_i     (trial),
    .b_i     ({1'b0, b_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  assign part_nx = borrow ? trial : diff;
  assign quo_nx  = {sh_q[N-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    sh_d    = sh_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B == '0) begin
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            q_d     = '1;
            r_d     = '1;
            cnt_d   = CW'(1);
            state_d = S_DONE;
          end else if (A[2*N-1:N] >= B) begin
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '1;
            cnt_d   = CW'(1);
            state_d = S_DONE;
          end else begin
            part_d  = {1'b0, A[2*N-1:N]};
            sh_d    = A[N-1:0];
            b_d     = B;
            cnt_d   = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        part_d = part_nx;
        sh_d   = quo_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          q_d     = quo_nx;
          r_d     = part_nx[N-1:0];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A nonzero count marks a special-path result that waits one
        // extra cycle before its done pulse.
        if (cnt_q != '0) begin
          cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      part_q  <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE) && (cnt_q == '0);
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;

endmodule
